bist_misr_checker: RTL
======================

BIST_MISR_CHECKER -- requirements
Module: bist_misr_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter CHAIN_LEN, default 8: scan-chain length in flops (legal range 1..255).
REQ-003 Parameter NUM_PATTERNS, default 16: capture cycles per test run (legal range 1..255).
REQ-004 Parameter GOLDEN_SIG, default 8'h00: expected final signature.
REQ-005 Port list:
  clk        in   1  rising-edge clock
  rst        in   1  synchronous active-high reset
  start      in   1  one-cycle request to begin a test run
  scan_out   in   1  serial response from the downstream scan chain
  scan_en    out  1  scan-chain mode select (1 = shift, 0 = capture)
  busy       out  1  high while a run is in progress
  done       out  1  high when the run has ended and the result is valid
  pass       out  1  final signature equals GOLDEN_SIG, valid while done = 1
  signature  out  8  current MISR contents

Function
REQ-006 The FSM SHALL have the states IDLE, SHIFT, CAPTURE, UNLOAD, COMPARE and DONE.
REQ-007 IDLE: start=1 -> SHIFT on the next cycle; shift_cnt and pattern_cnt clear to 0 and the MISR clears to 8'h00.
REQ-008 SHIFT: scan_en=1 for exactly CHAIN_LEN cycles, then -> CAPTURE.
REQ-009 CAPTURE: scan_en=0 for exactly 1 cycle, then the next state depends on the pattern count:
  - pattern_cnt==NUM_PATTERNS-1 -> UNLOAD;
  - otherwise pattern_cnt is incremented and the FSM -> SHIFT.
REQ-010 UNLOAD: scan_en=1 for exactly CHAIN_LEN cycles, then -> COMPARE.
REQ-011 COMPARE: 1 cycle; pass is registered as (signature==GOLDEN_SIG), then -> DONE.
REQ-012 DONE: done=1 and pass is held; start=1 -> SHIFT with the same clearing as REQ-007; otherwise the FSM stays in DONE.
REQ-013 MISR update rule:
  - On every cycle with scan_en=1: sig <= {sig[6:0], sig[7]^sig[3]^sig[2]^sig[1]^scan_out}.
  - On all other cycles sig holds its value.
REQ-014 scan_en and done SHALL be decoded from registered state only, with no combinational path from start.
REQ-015 busy SHALL be 1 in SHIFT, CAPTURE, UNLOAD and COMPARE, and 0 in IDLE and DONE.
REQ-016 start asserted while busy=1 SHALL be ignored.
REQ-017 Latency from the start-sampling edge to done=1 SHALL be NUM_PATTERNS*(CHAIN_LEN+1)+CHAIN_LEN+1 cycles (153 at defaults).
REQ-018 Counters SHALL be 8 bits wide and SHALL never wrap during a legal run.
REQ-019 The first SHIFT compacts the chain's post-reset contents; this is intended behaviour.

Reset
REQ-020 rst=1 SHALL force the FSM to IDLE, clear both counters, and set sig=8'h00, scan_en=0, busy=0, done=0 and pass=0 on the next edge.
REQ-021 rst SHALL take priority over start in the same cycle.
REQ-022 rst asserted mid-run SHALL abort the run with no result reported; a new start is then required.

Configuration
REQ-023 Macro BIST_LOOP_EN controls continuous testing.
  - Without BIST_LOOP_EN: behaviour is exactly as above.
  - With BIST_LOOP_EN: COMPARE -> SHIFT automatically, restarting per REQ-007, and done pulses for 1 cycle per run.
  - With BIST_LOOP_EN: pass becomes sticky-fail. It is set to 1 by the first COMPARE, is only cleared by a mismatch, and once 0 stays 0 until rst.

Verification
REQ-024 CHAIN_LEN=1, NUM_PATTERNS=1, scan_out=1 throughout, start pulse:
  - expect scan_en sequence 1,0,1;
  - expect signature 8'h03 in COMPARE;
  - expect done on cycle 4;
  - expect pass=1 iff GOLDEN_SIG=8'h03.
REQ-025 Defaults, scan_out=0 throughout, GOLDEN_SIG=8'h00 -> signature stays 8'h00, done at cycle 153, pass=1.
REQ-026 Defaults, scan_out driven by the real scan chain and pattern generator, with GOLDEN_SIG taken from a reference model:
  - expect pass=1;
  - flipping one scan_out bit mid-run -> expect pass=0.
REQ-027 Pulse start at cycle 20 of a run -> expect no effect on state, counters or the done timing.
REQ-028 Assert rst at cycle 50 of a run:
  - expect IDLE, scan_en=0, signature=8'h00, done=0 the next cycle;
  - a new start then gives a full-length run.
REQ-029 Configuration checks:
  - BIST_LOOP_EN defined, mismatch forced on run 2 of 3 -> expect pass=1,0,0 after each COMPARE.
  - Start in DONE (macro undefined) -> expect a fresh run with signature cleared.

Source files
------------

// File: rtl/bist_misr_checker.sv
// Scan-chain BIST controller: shift/capture sequencing, 8-bit MISR compaction and a golden compare.
// Optional macro BIST_LOOP_EN: continuous back-to-back runs with a sticky-fail pass flag.
module bist_misr_checker #(
  parameter int unsigned CHAIN_LEN    = 8,
  parameter int unsigned NUM_PATTERNS = 16,
  parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       scan_out,
  output logic       scan_en,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] UNLOAD  = 3'd3;
  localparam logic [2:0] COMPARE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [7:0] LAST_SHIFT   = 8'(CHAIN_LEN - 1);
  localparam logic [7:0] LAST_PATTERN = 8'(NUM_PATTERNS - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] shift_cnt;
  logic [7:0] pattern_cnt;
  logic [7:0] sig;
  logic       pass_r;
  logic       run_begin;
  logic       shifting;
  logic       shift_last;

`ifdef BIST_LOOP_EN
  logic       done_r;
  logic       first_cmp;
`endif

  function automatic logic [7:0] misr_next(input logic [7:0] cur, input logic din);
    misr_next = {cur[6:0], cur[7] ^ cur[3] ^ cur[2] ^ cur[1] ^ din};
  endfunction

  assign shifting   = (state == SHIFT) || (state == UNLOAD);
  assign shift_last = (shift_cnt == LAST_SHIFT);

  // A run (re)starts from IDLE/DONE on start, or automatically after COMPARE in loop mode.
  always_comb begin
    run_begin = 1'b0;
    if ((state == IDLE) || (state == DONE)) begin
      run_begin = start;
`ifdef BIST_LOOP_EN
    end else if (state == COMPARE) begin
      run_begin = 1'b1;
`endif
    end else begin
      run_begin = 1'b0;
    end
  end

  // Next-state decode; start is only honoured outside an active run.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
        else       state_nxt = IDLE;
      end
      SHIFT: begin
        if (shift_last) state_nxt = CAPTURE;
        else            state_nxt = SHIFT;
      end
      CAPTURE: begin
        if (pattern_cnt == LAST_PATTERN) state_nxt = UNLOAD;
        else                             state_nxt = SHIFT;
      end
      UNLOAD: begin
        if (shift_last) state_nxt = COMPARE;
        else            state_nxt = UNLOAD;
      end
      COMPARE: begin
`ifdef BIST_LOOP_EN
        state_nxt = SHIFT;
`else
        state_nxt = DONE;
`endif
      end
      DONE: begin
        if (start) state_nxt = SHIFT;
        else       state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and MISR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift_cnt   <= 8'd0;
      pattern_cnt <= 8'd0;
      sig         <= 8'h00;
    end else begin
      state <= state_nxt;
      if (shifting && !shift_last) shift_cnt <= shift_cnt + 8'd1;
      else                         shift_cnt <= 8'd0;
      if (run_begin)                                               pattern_cnt <= 8'd0;
      else if ((state == CAPTURE) && (pattern_cnt != LAST_PATTERN)) pattern_cnt <= pattern_cnt + 8'd1;
      else                                                         pattern_cnt <= pattern_cnt;
      if (run_begin)     sig <= 8'h00;
      else if (shifting) sig <= misr_next(sig, scan_out);
      else               sig <= sig;
    end
  end

`ifdef BIST_LOOP_EN
  // Sticky-fail verdict: the first compare loads it, later compares can only clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_r    <= 1'b0;
      first_cmp <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      done_r <= (state == COMPARE);
      if (state == COMPARE) begin
        pass_r    <= first_cmp ? (sig == GOLDEN_SIG) : (pass_r && (sig == GOLDEN_SIG));
        first_cmp <= 1'b0;
      end else begin
        pass_r    <= pass_r;
        first_cmp <= first_cmp;
      end
    end
  end

  assign done = done_r;
`else
  // Verdict is captured in COMPARE and held through DONE; a new run invalidates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_r <= 1'b0;
    end else if (state == COMPARE) begin
      pass_r <= (sig == GOLDEN_SIG);
    end else if (run_begin) begin
      pass_r <= 1'b0;
    end else begin
      pass_r <= pass_r;
    end
  end

  assign done = (state == DONE);
`endif

  assign scan_en   = shifting;
  assign busy      = (state == SHIFT) || (state == CAPTURE) || (state == UNLOAD) || (state == COMPARE);
  assign pass      = pass_r;
  assign signature = sig;

endmodule
